// File: rtl/intersection_pkg.sv
// Shared types and default timing for the intersection scheduler.
package intersection_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        ALL_RED = 2'd3
    } phase_t;

    localparam int unsigned N_DIR_DEF     = 4;
    localparam int unsigned GREEN_MIN_DEF = 4;
    localparam int unsigned GREEN_MAX_DEF = 12;
    localparam int unsigned YELLOW_T_DEF  = 3;
    localparam int unsigned ALLRED_T_DEF  = 2;
    localparam int unsigned CNT_W_DEF     = 4;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_picker #(
    parameter int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);

    int unsigned j;

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr) + i) % N;
            if (!any && req[j[W-1:0]]) begin
                any = 1'b1;
                idx = j[W-1:0];
            end
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// Round-robin intersection scheduler: grants green to one approach at a time
// and sequences each grant through GREEN -> YELLOW -> ALL_RED.
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int unsigned N_DIR     = N_DIR_DEF,
    parameter int unsigned GREEN_MIN = GREEN_MIN_DEF,
    parameter int unsigned GREEN_MAX = GREEN_MAX_DEF,
    parameter int unsigned YELLOW_T  = YELLOW_T_DEF,
    parameter int unsigned ALLRED_T  = ALLRED_T_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    localparam int unsigned DIR_W    = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DIR-1:0] req,
    output logic [N_DIR-1:0] red,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] green,
    output logic [DIR_W-1:0] cur_dir,
    output logic [1:0]       phase
);

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
    localparam logic [DIR_W-1:0] DIR_LAST  = DIR_W'(N_DIR - 1);

    phase_t           state;
    logic [CNT_W-1:0] timer;
    logic [DIR_W-1:0] ptr;
    logic [DIR_W-1:0] nxt_ptr;
    logic [DIR_W-1:0] pick_ptr;
    logic             pick_any;
    logic [DIR_W-1:0] pick_idx;
    logic             other;

    function automatic logic [N_DIR-1:0] onehot(input logic [DIR_W-1:0] d);
        logic [N_DIR-1:0] m;
        m    = '0;
        m[d] = 1'b1;
        return m;
    endfunction

    // Pointer after the current owner, used when leaving ALL_RED.
    assign nxt_ptr  = (cur_dir == DIR_LAST) ? '0 : cur_dir + DIR_W'(1);
    // Leaving ALL_RED arbitrates from past the owner; IDLE arbitrates from ptr.
    assign pick_ptr = (state == ALL_RED) ? nxt_ptr : ptr;
    // Any approach other than the owner waiting for green.
    assign other    = |(req & ~onehot(cur_dir));
    assign phase    = state;

    rr_picker #(.N(N_DIR)) u_picker (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Phase FSM, phase timer, rr pointer and registered lamp drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            ptr     <= '0;
            cur_dir <= '0;
            red     <= '1;
            yellow  <= '0;
            green   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state   <= GREEN;
                        cur_dir <= pick_idx;
                        timer   <= '0;
                        green   <= onehot(pick_idx);
                        red     <= ~onehot(pick_idx);
                    end
                end
                GREEN: begin
                    if (timer != '1) begin
                        timer <= timer + CNT_W'(1);
                    end
                    if (other && ((timer >= GMIN_LAST && !req[cur_dir]) ||
                                  timer >= GMAX_LAST)) begin
                        state  <= YELLOW;
                        timer  <= '0;
                        green  <= '0;
                        yellow <= onehot(cur_dir);
                    end
                end
                YELLOW: begin
                    if (timer >= Y_LAST) begin
                        state  <= ALL_RED;
                        timer  <= '0;
                        yellow <= '0;
                        red    <= '1;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                ALL_RED: begin
                    if (timer >= AR_LAST) begin
                        ptr   <= nxt_ptr;
                        timer <= '0;
                        if (pick_any) begin
                            state   <= GREEN;
                            cur_dir <= pick_idx;
                            green   <= onehot(pick_idx);
                            red     <= ~onehot(pick_idx);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
- Schedules a single N-approach intersection: shares the "green" resource among approach requesters (vehicle sensors) in round-robin order.
- Sequences each grant through GREEN -> YELLOW -> ALL_RED with min/max green timing, and drives per-direction red/yellow/green lamps.
- Sits above the per-lamp traffic_light-style controllers and replaces their single `control` input with an arbitrated schedule.

Parameters:
- N_DIR, 4, number of approaches (>=2).
- GREEN_MIN, 4, minimum green cycles once granted.
- GREEN_MAX, 12, maximum green cycles while another approach waits.
- YELLOW_T, 3, yellow cycles.
- ALLRED_T, 2, all-red clearance cycles.
- CNT_W, 4, phase timer width; must hold max(GREEN_MAX, YELLOW_T, ALLRED_T).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-low reset.
- req, input, N_DIR, level vehicle-presence per approach.
- red, output, N_DIR, red lamp per approach.
- yellow, output, N_DIR, yellow lamp per approach.
- green, output, N_DIR, green lamp per approach.
- cur_dir, output, $clog2(N_DIR), approach currently owning the phase.
- phase, output, 2, encoded FSM state (IDLE=0, GREEN=1, YELLOW=2, ALL_RED=3).

Behaviour:
- Reset (rst=0, asynchronous): phase=IDLE, red=all 1, yellow=0, green=0, cur_dir=0, rr pointer=0, timer=0. All outputs are registered.
- Invariant: at most one approach is non-red; green and yellow are never both set; the non-red approach is always cur_dir.
- Round-robin pick: first set bit of req scanning from ptr upward, with wrap mod N_DIR.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner from ptr. Next edge: phase=GREEN, cur_dir=winner, green[winner]=1, red[winner]=0, timer=0.
  - Latency: req seen at edge k gives green at edge k+1.
- GREEN: timer increments each cycle, saturating at 2^CNT_W-1. Let other = |(req & ~onehot(cur_dir)).
  - other=0: stay GREEN indefinitely (rest in green), whether or not req[cur_dir] is set.
  - other=1 and timer>=GREEN_MIN-1 and req[cur_dir]=0: go to YELLOW.
  - other=1 and timer>=GREEN_MAX-1: go to YELLOW regardless of req[cur_dir].
  - Green lasts exactly max(GREEN_MIN, cycles-until-own-req-drops), capped at GREEN_MAX, while others wait.
- YELLOW: yellow[cur_dir]=1, green=0, timer reset on entry. After YELLOW_T cycles go to ALL_RED.
- ALL_RED: all red=1 for ALLRED_T cycles. On the final cycle, ptr <= cur_dir+1 (mod N_DIR, 3 wraps to 0), then pick from the new ptr:
  - any req: go directly to GREEN for the winner. The same approach may win again only if it is the sole requester.
  - req==0: go to IDLE (cur_dir holds).
- Request changes during YELLOW/ALL_RED do not abort the sequence. Decisions are sampled only at the transition edges above.
- Reset mid-phase: lamps go to all-red immediately (asynchronous), with no yellow.

Decomposition:
- Package intersection_pkg: typedef enum logic [1:0] phase_t {IDLE, GREEN, YELLOW, ALL_RED}, plus timing defaults as localparams.
- Sub-module rr_picker (combinational): inputs req, ptr; outputs any, idx. Reused by other arbiters.
- The FSM, timer and lamp registers live in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random req -> red=4'b1111, yellow=0, green=0, phase=0; release with req=0 for 10 cycles -> stays IDLE.
- Single requester: req=4'b0100 held -> green=4'b0100 one cycle after sample; stays GREEN for 30+ cycles with no yellow.
- Contention: req=4'b0011 held -> dir0 green 12 cycles, yellow 3, all-red 2, then dir1 green next cycle; dir0 regains green only after dir1's cycle.
- Min green: req[3]=1 held; 1-cycle pulse on req[0] from IDLE with ptr=0 -> dir0 green exactly 4 cycles, then yellow 3, all-red 2, then dir3 green.
- Wrap and skip: ptr at dir3, req=4'b1001 after dir3's phase -> next grant is dir0 (3->0 wrap); req=4'b0101 from ptr=1 -> dir2 wins, dir1 is skipped.
- Reset mid-YELLOW: rst low while yellow[1]=1 -> same timestep red=all 1, yellow=0; after release with req=0 -> IDLE, cur_dir=0.
- All scenarios: assert the one-non-red invariant every cycle.
